// File: rtl/bitslip_aligner_pkg.sv
// Shared definitions for the frame-clock bitslip aligner: FSM state encoding
// and default alignment parameters.
package bitslip_aligner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [7:0] DEF_TARGET        = 8'h0F;
    localparam int         DEF_SETTLE_CYCLES = 4;
    localparam int         DEF_LOCK_COUNT    = 16;
    localparam int         DEF_MAX_SLIPS     = 16;
    localparam int         DEF_UNLOCK_MISSES = 4;

endpackage

// File: rtl/bitslip_aligner.sv
// Word aligner for an ISERDES frame clock: pulses bitslip until the
// deserialized word matches TARGET, then monitors the alignment.
module bitslip_aligner
    import bitslip_aligner_pkg::*;
#(
    parameter logic [7:0] TARGET        = DEF_TARGET,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int         LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int         MAX_SLIPS     = DEF_MAX_SLIPS,
    parameter int         UNLOCK_MISSES = DEF_UNLOCK_MISSES
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic [7:0] clk_data_out,
    input  logic       enable,
    output logic       bitslip,
    output logic       locked,
    output logic       align_err,
    output logic [4:0] slip_count,
    output logic [2:0] state_dbg
);

    localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W   = $clog2(UNLOCK_MISSES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);

    localparam logic [MATCH_W-1:0]  MATCH_MAX   = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]   MISS_MAX    = MISS_W'(UNLOCK_MISSES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);

    state_t                state_q, state_d;
    logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [SLIP_W-1:0]     slip_cnt_q, slip_cnt_d;
    logic                  bitslip_q, bitslip_d;
    logic                  locked_q, locked_d;
    logic                  align_err_q, align_err_d;

    logic                  word_match;
    logic [MATCH_W-1:0]    match_inc;
    logic [MISS_W-1:0]     miss_inc;

    assign word_match = (clk_data_out == TARGET);
    assign match_inc  = (match_cnt_q < MATCH_MAX) ? match_cnt_q + MATCH_W'(1) : match_cnt_q;
    assign miss_inc   = (miss_cnt_q < MISS_MAX) ? miss_cnt_q + MISS_W'(1) : miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        settle_cnt_d = settle_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        bitslip_d    = 1'b0;
        locked_d     = locked_q;
        align_err_d  = align_err_q;

        // Dropping enable wins over everything, including a pulse in flight.
        if (!enable) begin
            state_d      = ST_IDLE;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
            settle_cnt_d = '0;
            slip_cnt_d   = '0;
            locked_d     = 1'b0;
            align_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    match_cnt_d  = '0;
                    miss_cnt_d   = '0;
                    settle_cnt_d = '0;
                    slip_cnt_d   = '0;
                    locked_d     = 1'b0;
                    align_err_d  = 1'b0;
                    state_d      = ST_CHECK;
                end
                ST_CHECK: begin
                    if (word_match) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MATCH_MAX) begin
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q < SLIP_MAX) begin
                            state_d    = ST_SLIP;
                            bitslip_d  = 1'b1;
                            slip_cnt_d = slip_cnt_q + SLIP_W'(1);
                        end else begin
                            state_d     = ST_FAIL;
                            align_err_d = 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        match_cnt_d = '0;
                        state_d     = ST_CHECK;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (word_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            state_d     = ST_CHECK;
                            locked_d    = 1'b0;
                            slip_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
                ST_FAIL: begin
                    locked_d    = 1'b0;
                    align_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            settle_cnt_q <= '0;
            slip_cnt_q   <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            align_err_q  <= align_err_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign align_err  = align_err_q;
    assign slip_count = 5'(slip_cnt_q);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_bitslip_aligner.sv
// Bench for bitslip_aligner: an ISERDES model rotates TARGET one bit per
// bitslip pulse; an event scoreboard checks pulse, lock and error timing.
`timescale 1ns/1ps
module tb_bitslip_aligner;
    import bitslip_aligner_pkg::*;

    localparam int         W         = 20;
    localparam logic [3:0] EV_SLIP   = 4'd1;
    localparam logic [3:0] EV_LOCK_R = 4'd2;
    localparam logic [3:0] EV_LOCK_F = 4'd3;
    localparam logic [3:0] EV_ERR_R  = 4'd4;
    localparam logic [3:0] EV_ERR_F  = 4'd5;
    localparam logic [7:0] BAD_WORD  = 8'hA5;

    logic       sample_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] clk_data_out;
    logic       bitslip;
    logic       locked;
    logic       align_err;
    logic [4:0] slip_count;
    logic [2:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           phase = 0;
    int           bad_left = 0;
    logic         stuck = 1'b0;
    logic         locked_prev = 1'b0;
    logic         err_prev = 1'b0;

    bitslip_aligner dut (
        .sample_clk   (sample_clk),
        .reset        (reset),
        .clk_data_out (clk_data_out),
        .enable       (enable),
        .bitslip      (bitslip),
        .locked       (locked),
        .align_err    (align_err),
        .slip_count   (slip_count),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    always #5 sample_clk = ~sample_clk;
    always @(posedge sample_clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [15:0] d;
        d = {w, w} << n;
        return d[15:8];
    endfunction

    task automatic evt_seen(input logic [3:0] t);
        logic [W-1:0] got;
        got = {t, 16'(cyc)};
        if (exp_q.size() == 0) check("unexpected_event", 32'(got), 32'd0);
        else check("event", 32'(got), 32'(exp_q.pop_front()));
    endtask

    // monitor + ISERDES model, on the falling edge
    always @(negedge sample_clk) begin
        if (bitslip === 1'b1) begin
            evt_seen(EV_SLIP);
            phase = (phase + 7) % 8;
        end
        if (locked === 1'b1 && locked_prev === 1'b0) evt_seen(EV_LOCK_R);
        if (locked === 1'b0 && locked_prev === 1'b1) evt_seen(EV_LOCK_F);
        if (align_err === 1'b1 && err_prev === 1'b0) evt_seen(EV_ERR_R);
        if (align_err === 1'b0 && err_prev === 1'b1) evt_seen(EV_ERR_F);
        locked_prev = locked;
        err_prev    = align_err;
        if (bad_left > 0) begin
            clk_data_out = BAD_WORD;
            bad_left     = bad_left - 1;
        end else if (stuck) begin
            clk_data_out = 8'h00;
        end else begin
            clk_data_out = rotl8(DEF_TARGET, phase);
        end
    end

    // driver tasks: act 2 ns after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge sample_clk);
        #2;
    endtask

    task automatic push_evt(input logic [3:0] t, input int c);
        exp_q.push_back({t, 16'(c)});
    endtask

    // Enable (or keep enabled) a search from phase p and queue its timing:
    // first pulse one cycle after CHECK's first sample, pulses 6 apart,
    // lock on the 16th matching sample, error on the check after the 16th slip.
    task automatic start_search(input int p, input bit expect_fail);
        int e;
        int n;
        n     = expect_fail ? DEF_MAX_SLIPS : p;
        phase = p;
        e     = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k < n; k++) push_evt(EV_SLIP, e + 1 + 6 * k);
        if (expect_fail) push_evt(EV_ERR_R, e + 1 + 6 * n);
        else push_evt(EV_LOCK_R, e + 1 + 6 * n + 15);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic disable_search(input bit was_locked, input bit had_err);
        enable = 1'b0;
        if (was_locked) push_evt(EV_LOCK_F, cyc + 1);
        if (had_err) push_evt(EV_ERR_F, cyc + 1);
        tick(1);
        check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
        tick(1);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        clk_data_out = 8'h00;
        tick(3);
        check("rst_bitslip", 32'(bitslip), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_slip_count", 32'(slip_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        tick(2);

        // aligned from the start
        start_search(0, 1'b0);
        tick(1);
        check("p0_leave_idle", 32'(state_dbg), 32'(ST_CHECK));
        drain(200);
        check("p0_locked", 32'(locked), 32'd1);
        check("p0_slip_count", 32'(slip_count), 32'd0);

        // three misses keep lock, four drop it and re-search from zero slips
        bad_left = 3;
        tick(6);
        check("miss3_locked", 32'(locked), 32'd1);
        check("miss3_state", 32'(state_dbg), 32'(ST_LOCKED));
        bad_left = 4;
        push_evt(EV_LOCK_F, cyc + 4);
        push_evt(EV_LOCK_R, cyc + 20);
        tick(3);
        check("miss4_locked_before", 32'(locked), 32'd1);
        tick(1);
        check("miss4_locked_drop", 32'(locked), 32'd0);
        check("miss4_state", 32'(state_dbg), 32'(ST_CHECK));
        check("miss4_slip_count", 32'(slip_count), 32'd0);
        drain(100);
        check("relock", 32'(locked), 32'd1);
        disable_search(1'b1, 1'b0);

        // three-bit phase offset
        check("p3_initial_word", 32'(rotl8(DEF_TARGET, 3)), 32'h78);
        start_search(3, 1'b0);
        drain(200);
        check("p3_locked", 32'(locked), 32'd1);
        check("p3_slip_count", 32'(slip_count), 32'd3);
        disable_search(1'b1, 1'b0);

        // word stuck low: exhaust slips, hold FAIL, then restart
        stuck = 1'b1;
        start_search(0, 1'b1);
        drain(300);
        check("stuck_align_err", 32'(align_err), 32'd1);
        check("stuck_locked", 32'(locked), 32'd0);
        check("stuck_state", 32'(state_dbg), 32'(ST_FAIL));
        check("stuck_slip_count", 32'(slip_count), 32'd16);
        tick(20);
        check("stuck_hold", 32'(state_dbg), 32'(ST_FAIL));
        disable_search(1'b0, 1'b1);
        check("toggle_align_err", 32'(align_err), 32'd0);
        check("toggle_slip_count", 32'(slip_count), 32'd0);
        stuck = 1'b0;
        start_search(2, 1'b0);
        tick(2);
        check("restart_first_slip", 32'(slip_count), 32'd1);
        drain(200);
        check("restart_slip_count", 32'(slip_count), 32'd2);
        disable_search(1'b1, 1'b0);

        // reset asserted mid-SETTLE of a five-slip search
        phase  = 5;
        push_evt(EV_SLIP, cyc + 2);
        enable = 1'b1;
        tick(3);
        check("rst_mid_state", 32'(state_dbg), 32'(ST_SETTLE));
        reset = 1'b1;
        #1;
        check("rst_mid_bitslip", 32'(bitslip), 32'd0);
        check("rst_mid_locked", 32'(locked), 32'd0);
        check("rst_mid_align_err", 32'(align_err), 32'd0);
        check("rst_mid_slip_count", 32'(slip_count), 32'd0);
        check("rst_mid_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick(2);
        reset = 1'b0;
        start_search(5, 1'b0);
        drain(200);
        check("p5_locked", 32'(locked), 32'd1);
        check("p5_slip_count", 32'(slip_count), 32'd5);
        disable_search(1'b1, 1'b0);

        // enable dropped during the SLIP cycle
        phase  = 1;
        push_evt(EV_SLIP, cyc + 2);
        enable = 1'b1;
        tick(2);
        check("drop_slip_pulse", 32'(bitslip), 32'd1);
        check("drop_slip_state", 32'(state_dbg), 32'(ST_SLIP));
        enable = 1'b0;
        tick(1);
        check("drop_no_extend", 32'(bitslip), 32'd0);
        check("drop_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("drop_slip_count", 32'(slip_count), 32'd0);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
